// File: rtl/cnn_job_ctrl_pkg.sv
// Shared types for the quad-side job controller: FSM states, the
// job_parameters bit map and the decoded configuration record.
package cnn_job_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACCEPT, ST_FETCH_REQ, ST_FETCH_WAIT, ST_RUN, ST_DONE
  } state_t;

  localparam int ROWS_LSB   = 0;   localparam int ROWS_W   = 10;
  localparam int COLS_LSB   = 10;  localparam int COLS_W   = 10;
  localparam int NKERN_LSB  = 20;  localparam int NKERN_W  = 7;
  localparam int KSIZE_LSB  = 27;  localparam int KSIZE_W  = 5;
  localparam int STRIDE_LSB = 32;  localparam int STRIDE_W = 7;
  localparam int PAD_LSB    = 39;  localparam int PAD_W    = 5;
  localparam int UPS_LSB    = 44;
  // Bits at and above this index are reserved.
  localparam int PARAM_USED_W = 45;

  typedef struct packed {
    logic                upsample;
    logic [PAD_W-1:0]    padding;
    logic [STRIDE_W-1:0] stride;
    logic [KSIZE_W-1:0]  ksize;
    logic [NKERN_W-1:0]  nkern;
    logic [COLS_W-1:0]   cols;
    logic [ROWS_W-1:0]   rows;
  } job_cfg_t;

  function automatic job_cfg_t decode_params(input logic [PARAM_USED_W-1:0] p);
    job_cfg_t c;
    c.rows     = p[ROWS_LSB   +: ROWS_W];
    c.cols     = p[COLS_LSB   +: COLS_W];
    c.nkern    = p[NKERN_LSB  +: NKERN_W];
    c.ksize    = p[KSIZE_LSB  +: KSIZE_W];
    c.stride   = p[STRIDE_LSB +: STRIDE_W];
    c.padding  = p[PAD_LSB    +: PAD_W];
    c.upsample = p[UPS_LSB];
    return c;
  endfunction

endpackage

// File: rtl/cnn_job_param_decode.sv
// Latches the decoded job fields on job acceptance and flags descriptors
// the datapath cannot execute (only when CNN_JOB_PARAM_CHECK_EN is defined).
module cnn_job_param_decode
  import cnn_job_ctrl_pkg::*;
(
  input  logic                    clk_if,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [PARAM_USED_W-1:0] params,
  output job_cfg_t                cfg,
  output logic                    param_bad
);

  // Configuration register: only written when a job is taken from IDLE.
  always_ff @(posedge clk_if) begin
    if (!rst_n)    cfg <= '0;
    else if (load) cfg <= decode_params(params);
  end

  // Zero kernel size, stride or kernel count would stall the datapath.
  always_comb begin
`ifdef CNN_JOB_PARAM_CHECK_EN
    param_bad = (cfg.ksize == '0) || (cfg.stride == '0) || (cfg.nkern == '0);
`else
    param_bad = 1'b0;
`endif
  end

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Quad-side job handshake responder: accept, fetch, execute, complete.
// Optional parameter check enabled by defining CNN_JOB_PARAM_CHECK_EN.
module cnn_layer_accel_job_ctrl
  import cnn_job_ctrl_pkg::*;
#(
  parameter int C_JOB_CNT_WIDTH = 16,
  parameter int C_PARAM_WIDTH   = 128
) (
  input  logic                       clk_if,
  input  logic                       rst_n,
  input  logic                       job_start,
  output logic                       job_accept,
  input  logic [C_PARAM_WIDTH-1:0]   job_parameters,
  output logic                       job_fetch_request,
  input  logic                       job_fetch_ack,
  input  logic                       job_fetch_complete,
  output logic                       job_complete,
  input  logic                       job_complete_ack,
  output logic                       exec_start,
  input  logic                       exec_done,
  output logic [9:0]                 num_output_rows_cfg,
  output logic [9:0]                 num_output_cols_cfg,
  output logic [6:0]                 num_kernel_cfg,
  output logic [4:0]                 kernel_size_cfg,
  output logic [6:0]                 convolution_stride_cfg,
  output logic [4:0]                 padding_cfg,
  output logic                       upsample_cfg,
  output logic [C_JOB_CNT_WIDTH-1:0] job_count,
  output logic                       job_error
);

  state_t   state, nxt;
  job_cfg_t cfg;
  logic     param_bad;

  // Reserved descriptor bits are deliberately dropped.
  logic unused_rsvd;
  assign unused_rsvd = ^job_parameters[C_PARAM_WIDTH-1:PARAM_USED_W];

  cnn_job_param_decode u_decode (
    .clk_if    (clk_if),
    .rst_n     (rst_n),
    .load      ((state == ST_IDLE) && job_start),
    .params    (job_parameters[PARAM_USED_W-1:0]),
    .cfg       (cfg),
    .param_bad (param_bad)
  );

  assign num_output_rows_cfg    = cfg.rows;
  assign num_output_cols_cfg    = cfg.cols;
  assign num_kernel_cfg         = cfg.nkern;
  assign kernel_size_cfg        = cfg.ksize;
  assign convolution_stride_cfg = cfg.stride;
  assign padding_cfg            = cfg.padding;
  assign upsample_cfg           = cfg.upsample;

  // Next-state logic; each state only listens to its own handshake input.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:       if (job_start) nxt = ST_ACCEPT;
      ST_ACCEPT:     nxt = param_bad ? ST_DONE : ST_FETCH_REQ;
      ST_FETCH_REQ:  if (job_fetch_ack) nxt = job_fetch_complete ? ST_RUN : ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (job_fetch_complete) nxt = ST_RUN;
      // exec_done coinciding with the launch pulse belongs to a previous run.
      ST_RUN:        if (exec_done && !exec_start) nxt = ST_DONE;
      ST_DONE:       if (job_complete_ack) nxt = ST_IDLE;
      default:       nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      job_accept        <= 1'b0;
      job_fetch_request <= 1'b0;
      exec_start        <= 1'b0;
      job_complete      <= 1'b0;
      job_error         <= 1'b0;
      job_count         <= '0;
    end else begin
      state             <= nxt;
      job_accept        <= (nxt == ST_ACCEPT);
      job_fetch_request <= (nxt == ST_FETCH_REQ);
      exec_start        <= (nxt == ST_RUN) && (state != ST_RUN);
      job_complete      <= (nxt == ST_DONE);
`ifdef CNN_JOB_PARAM_CHECK_EN
      // Only the ACCEPT->DONE shortcut raises the error; it holds through DONE.
      job_error         <= (nxt == ST_DONE) && ((state == ST_ACCEPT) || job_error);
`else
      job_error         <= 1'b0;
`endif
      if (state == ST_RUN && nxt == ST_DONE)
        job_count <= job_count + C_JOB_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Scoreboard bench: the driver pushes the expected completion record for
// each job; a forked monitor pops and compares when job_complete rises.
module tb_cnn_layer_accel_job_ctrl;

  localparam int CW = 4;  // narrow counter so wrap-around is reached quickly

  logic         clk_if = 1'b0, rst_n = 1'b0;
  logic         job_start = 1'b0, job_fetch_ack = 1'b0, job_fetch_complete = 1'b0;
  logic         job_complete_ack = 1'b0, exec_done = 1'b0;
  logic [127:0] job_parameters = '0;
  logic         job_accept, job_fetch_request, job_complete, exec_start, job_error;
  logic [9:0]   rows, cols;
  logic [6:0]   nkern, stride;
  logic [4:0]   ksize, pad;
  logic         ups;
  logic [CW-1:0] job_count;

  cnn_layer_accel_job_ctrl #(.C_JOB_CNT_WIDTH(CW), .C_PARAM_WIDTH(128)) dut (
    .clk_if(clk_if), .rst_n(rst_n), .job_start(job_start), .job_accept(job_accept),
    .job_parameters(job_parameters), .job_fetch_request(job_fetch_request),
    .job_fetch_ack(job_fetch_ack), .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .exec_start(exec_start), .exec_done(exec_done),
    .num_output_rows_cfg(rows), .num_output_cols_cfg(cols), .num_kernel_cfg(nkern),
    .kernel_size_cfg(ksize), .convolution_stride_cfg(stride), .padding_cfg(pad),
    .upsample_cfg(ups), .job_count(job_count), .job_error(job_error)
  );

  always #5 clk_if = ~clk_if;

  typedef struct {
    logic [44:0] cfg;
    bit          err;
    int          cnt;
    int          nexec;
    bit          fetch;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   model_cnt = 0;
  logic prev_c = 1'b0;
  int   n_exec = 0;
  bit   saw_fetch = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [127:0] p);
`ifdef CNN_JOB_PARAM_CHECK_EN
    return (p[31:27] == 0) || (p[38:32] == 0) || (p[26:20] == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [127:0] mk(input int r, c, nk, ks, st, pd, up);
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[9:0] = 10'(r);  p[19:10] = 10'(c); p[26:20] = 7'(nk); p[31:27] = 5'(ks);
    p[38:32] = 7'(st); p[43:39] = 5'(pd); p[44] = 1'(up);
    return p;
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({job_accept, job_fetch_request, job_complete, exec_start, job_error,
                job_count, ups, pad, stride, ksize, nkern, cols, rows});
  endfunction

  function automatic logic sel(input int w);
    return (w == 0) ? job_fetch_request : job_complete;
  endfunction

  task automatic step();
    @(posedge clk_if); #1;
  endtask

  task automatic wait_hi(input int w, input string name);
    int n = 0;
    while (!sel(w) && n < 200) begin step(); n++; end
    chk(name, 64'(sel(w)), 64'd1);
  endtask

  // Counts per-job activity and checks each completion against the queue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_if);
      if (job_accept) begin n_exec = 0; saw_fetch = 0; end
      if (exec_start) n_exec++;
      if (job_fetch_request) saw_fetch = 1;
      if (job_complete && !prev_c) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_complete: job_complete rose with no job pending @%0t", $time);
        end else begin
          e = q.pop_front();
          chk("cfg", 64'({ups, pad, stride, ksize, nkern, cols, rows}), 64'(e.cfg));
          chk("job_error", 64'(job_error), 64'(e.err));
          chk("job_count", 64'(job_count), 64'(e.cnt));
          chk("exec_start_pulses", 64'(n_exec), 64'(e.nexec));
          chk("fetch_request_seen", 64'(saw_fetch), 64'(e.fetch));
        end
      end
      prev_c = job_complete;
    end
  endtask

  task automatic run_job(input logic [127:0] p, input int fa, input bit same, input int fc,
                         input int ed, input bit dbl, input int ack_dly,
                         input bit early, input logic [127:0] pn);
    exp_t e;
    e.cfg = p[44:0];
    e.err = model_err(p);
    if (!e.err) model_cnt = (model_cnt + 1) % (1 << CW);
    e.cnt = model_cnt;
    e.nexec = e.err ? 0 : 1;
    e.fetch = !e.err;
    q.push_back(e);
    job_parameters = p; job_start = 1'b1;
    step();
    chk("accept_latency", 64'(job_accept), 64'd1);
    job_start = 1'b0;
    job_parameters = {$urandom, $urandom, $urandom, $urandom};
    if (!e.err) begin
      wait_hi(0, "fetch_request_wait");
      for (int i = 0; i < fa; i++) step();
      job_fetch_ack = 1'b1; job_fetch_complete = same;
      step();
      job_fetch_ack = 1'b0; job_fetch_complete = 1'b0;
      if (!same) begin
        chk("fetch_request_drop", 64'(job_fetch_request), 64'd0);
        for (int i = 0; i < fc; i++) step();
        job_fetch_complete = 1'b1;
        step();
        job_fetch_complete = 1'b0;
      end
      chk("exec_start_latency", 64'(exec_start), 64'd1);
      exec_done = dbl;
      step();
      exec_done = 1'b0;
      chk("exec_done_with_start_ignored", 64'({exec_start, job_complete}), 64'd0);
      for (int i = 0; i < ed; i++) step();
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
      chk("complete_latency", 64'(job_complete), 64'd1);
    end
    wait_hi(1, "complete_wait");
    for (int i = 0; i < ack_dly; i++) begin
      if (early && i == 0) begin job_start = 1'b1; job_parameters = pn; end
      step();
      chk("complete_held", 64'(job_complete), 64'd1);
      chk("no_accept_in_done", 64'(job_accept), 64'd0);
    end
    job_complete_ack = 1'b1;
    step();
    job_complete_ack = 1'b0;
    chk("complete_clear", 64'({job_complete, job_error}), 64'd0);
  endtask

  logic [127:0] p8;

  initial begin
    fork monitor(); join_none

    // Reset state
    step(); step();
    chk("reset_outputs", all_out(), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: nominal job
    run_job(mk(32, 32, 16, 3, 1, 1, 0), 2, 0, 5, 20, 0, 0, 0, '0);
    // 2: fetch ack and complete together, plus exec_done alongside exec_start
    run_job(mk(64, 48, 8, 5, 2, 2, 1), 0, 1, 0, 3, 1, 0, 0, '0);
    // 3: delayed completion ack with a new job_start held during DONE
    p8 = mk(8, 16, 4, 3, 1, 0, 0);
    run_job(mk(20, 20, 2, 1, 1, 0, 0), 1, 0, 2, 4, 0, 10, 1, p8);
    run_job(p8, 0, 0, 0, 0, 0, 2, 0, '0);

    // 4: reset while running, later exec_done must not complete anything
    q.push_back('{cfg: 45'd0, err: 1'b0, cnt: 0, nexec: 0, fetch: 1'b0});
    job_parameters = mk(10, 10, 3, 3, 1, 0, 0); job_start = 1'b1;
    step();
    job_start = 1'b0;
    wait_hi(0, "rst_fetch_wait");
    job_fetch_ack = 1'b1; job_fetch_complete = 1'b1;
    step();
    job_fetch_ack = 1'b0; job_fetch_complete = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("abort_outputs", all_out(), 64'd0);
    void'(q.pop_back());
    model_cnt = 0;
    rst_n = 1'b1;
    step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    step(); step();
    chk("no_complete_after_abort", 64'({job_complete, job_count}), 64'd0);

    // 5: zero kernel size (rejected only when the check is built in)
    run_job(mk(16, 16, 4, 0, 1, 0, 0), 1, 0, 1, 2, 0, 0, 0, '0);

    // 6: randomized jobs, enough to wrap the counter
    for (int j = 0; j < 24; j++) begin
      run_job(mk($urandom_range(0, 1023), $urandom_range(0, 1023),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127),
                 ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127),
                 $urandom_range(0, 31), $urandom_range(0, 1)),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
              $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              0, '0);
    end

    step(); step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d jobs still pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
